// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks {a,b,c,d} through 0..15, holds each vector for
// SETTLE cycles, samples f_in once per vector, then compares the captured table
// against EXPECT and reports pass, the set-bit count and the lowest failing index.
module truth_table_sequencer #(
    parameter int unsigned SETTLE = 1,
    parameter logic [15:0] EXPECT = 16'h0222
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_out,
    output logic [4:0]  ones,
    output logic        pass,
    output logic [3:0]  first_fail
);

    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] SETTLE_LAST = IDX_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(15);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic [IDX_W-1:0] scnt;
    logic [IDX_W-1:0] scnt_nx;
    logic [3:0]       vec_nx;
    logic             busy_nx;
    logic             done_nx;
    logic [15:0]      table_nx;
    logic [4:0]       ones_nx;
    logic             pass_nx;
    logic [3:0]       first_fail_nx;
    logic [15:0]      sampled_c;
    logic [15:0]      miss_c;
    logic [3:0]       lowest_miss_c;

    // Next-state, datapath updates and next values for every registered output.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        scnt_nx       = scnt;
        table_nx      = table_out;
        ones_nx       = ones;
        pass_nx       = pass;
        first_fail_nx = first_fail;

        // Table as it will look once the current vector's sample is included.
        sampled_c      = table_out;
        sampled_c[idx] = f_in;
        miss_c         = sampled_c ^ EXPECT;

        // Scan downward so the lowest mismatching index wins.
        lowest_miss_c = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (miss_c[i]) begin
                lowest_miss_c = 4'(i);
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx      = DRIVE;
                    idx_nx        = '0;
                    scnt_nx       = '0;
                    table_nx      = 16'd0;
                    ones_nx       = 5'd0;
                    pass_nx       = 1'b0;
                    first_fail_nx = 4'd0;
                end
            end
            DRIVE: begin
                if (scnt == SETTLE_LAST) begin
                    state_nx = SAMPLE;
                    scnt_nx  = '0;
                end else begin
                    scnt_nx = scnt + IDX_W'(1);
                end
            end
            SAMPLE: begin
                table_nx = sampled_c;
                ones_nx  = ones + 5'(f_in);
                if (idx == LAST_IDX) begin
                    state_nx      = DONE;
                    pass_nx       = (miss_c == 16'd0);
                    first_fail_nx = lowest_miss_c;
                end else begin
                    state_nx = DRIVE;
                    idx_nx   = idx + IDX_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight from flops.
        busy_nx = (state_nx == DRIVE) || (state_nx == SAMPLE);
        done_nx = (state_nx == DONE);
        vec_nx  = busy_nx ? idx_nx : 4'd0;
    end

    // State, counters and all outputs; synchronous reset aborts any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            scnt         <= '0;
            {a, b, c, d} <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= 16'd0;
            ones         <= 5'd0;
            pass         <= 1'b0;
            first_fail   <= 4'd0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            scnt         <= scnt_nx;
            {a, b, c, d} <= vec_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            table_out    <= table_nx;
            ones         <= ones_nx;
            pass         <= pass_nx;
            first_fail   <= first_fail_nx;
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a SETTLE=1 instance driven by several
// datapath models, and a SETTLE=3 instance used for vector timing.
module tb_truth_table_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1;
    logic        f_in1;
    logic        a1, b1, c1, d1, busy1, done1, pass1;
    logic [15:0] table1;
    logic [4:0]  ones1;
    logic [3:0]  ff1;
    logic [2:0]  mode1;

    logic        start3;
    logic        f_in3;
    logic        a3, b3, c3, d3, busy3, done3, pass3;
    logic [15:0] table3;
    logic [4:0]  ones3;
    logic [3:0]  ff3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] table_exp;
        logic [4:0]  ones_exp;
        logic        pass_exp;
        logic [3:0]  ff_exp;
    } rec_t;

    rec_t recs[5];

    always #5 clk = ~clk;

    // Datapath models: 0 correct, 1 stuck-0, 2 inverted, 3 stuck-1, 4 f=d.
    always_comb begin
        case (mode1)
            3'd0:    f_in1 = !((a1 & b1) | c1) & d1;
            3'd1:    f_in1 = 1'b0;
            3'd2:    f_in1 = !(!((a1 & b1) | c1) & d1);
            3'd3:    f_in1 = 1'b1;
            default: f_in1 = d1;
        endcase
    end

    always_comb f_in3 = !((a3 & b3) | c3) & d3;

    truth_table_sequencer #(.SETTLE(1), .EXPECT(16'h0222)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .f_in(f_in1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .table_out(table1), .ones(ones1), .pass(pass1), .first_fail(ff1)
    );

    truth_table_sequencer #(.SETTLE(3), .EXPECT(16'h0222)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .f_in(f_in3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .table_out(table3), .ones(ones3), .pass(pass3), .first_fail(ff3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_results1(input string name, input rec_t r);
        chk({name, " table_out"}, table1, r.table_exp);
        chk({name, " ones"}, ones1, r.ones_exp);
        chk({name, " pass"}, pass1, r.pass_exp);
        chk({name, " first_fail"}, ff1, r.ff_exp);
    endtask

    // One SETTLE=1 run through cycle 34, optionally poking start mid-run.
    task automatic run1(input bit extra_starts);
        int exp_vec;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            exp_vec = (n <= 32) ? (n - 1) / 2 : 0;
            chk($sformatf("s1 done c%0d", n), done1, (n == 33));
            chk($sformatf("s1 busy c%0d", n), busy1, (n <= 32));
            chk($sformatf("s1 vec c%0d", n), {a1, b1, c1, d1}, exp_vec);
            start1 = extra_starts && (n == 5 || n == 20);
        end
        start1 = 1'b0;
    endtask

    initial begin
        rec_t good;
        int   exp_vec;
        bit   exp_busy;

        recs[0] = '{3'd0, 16'h0222, 5'd3,  1'b1, 4'd0};
        recs[1] = '{3'd1, 16'h0000, 5'd0,  1'b0, 4'd1};
        recs[2] = '{3'd2, 16'hFDDD, 5'd13, 1'b0, 4'd0};
        recs[3] = '{3'd3, 16'hFFFF, 5'd16, 1'b0, 4'd0};
        recs[4] = '{3'd4, 16'hAAAA, 5'd8,  1'b0, 4'd3};
        good    = recs[0];

        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode1  = 3'd0;
        repeat (3) @(negedge clk);
        chk("reset vec", {a1, b1, c1, d1}, 4'd0);
        chk("reset busy", busy1, 1'b0);
        chk("reset done", done1, 1'b0);
        chk_results1("reset", '{3'd0, 16'h0000, 5'd0, 1'b0, 4'd0});
        chk("reset table3", table3, 16'h0000);
        rst = 1'b0;

        // Table-driven datapath models.
        for (int k = 0; k < 5; k++) begin
            mode1 = recs[k].mode;
            run1(1'b0);
            chk_results1($sformatf("model%0d", k), recs[k]);
        end

        // Start pulses during a run must not restart it.
        mode1 = 3'd0;
        run1(1'b1);
        chk_results1("restart_ignored", good);

        // Reset mid-run aborts, then a fresh run completes.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n < 10) begin
                chk($sformatf("rst busy c%0d", n), busy1, 1'b1);
            end
            if (n >= 11) begin
                chk($sformatf("rst done c%0d", n), done1, 1'b0);
                chk($sformatf("rst busy c%0d", n), busy1, 1'b0);
                chk($sformatf("rst vec c%0d", n), {a1, b1, c1, d1}, 4'd0);
                chk($sformatf("rst table c%0d", n), table1, 16'h0000);
                chk($sformatf("rst ones c%0d", n), ones1, 5'd0);
            end
            if (n == 10) rst = 1'b1;
            if (n == 11) rst = 1'b0;
        end
        run1(1'b0);
        chk_results1("after_reset", good);

        // SETTLE=3 vector timing and ordering.
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        for (int n = 1; n <= 66; n++) begin
            @(negedge clk);
            exp_vec = (n <= 64) ? (n - 1) / 4 : 0;
            chk($sformatf("s3 vec c%0d", n), {a3, b3, c3, d3}, exp_vec);
            chk($sformatf("s3 done c%0d", n), done3, (n == 65));
            chk($sformatf("s3 busy c%0d", n), busy3, (n <= 64));
        end
        chk("s3 table_out", table3, 16'h0222);
        chk("s3 ones", ones3, 5'd3);
        chk("s3 pass", pass3, 1'b1);
        chk("s3 first_fail", ff3, 4'd0);

        // Continuous start: back-to-back runs.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 68; n++) begin
            @(negedge clk);
            exp_busy = (n <= 32) || (n >= 35 && n <= 66);
            chk($sformatf("cont done c%0d", n), done1, (n == 33 || n == 67));
            chk($sformatf("cont busy c%0d", n), busy1, exp_busy);
            if (n == 33 || n == 34 || n == 67) begin
                chk($sformatf("cont table c%0d", n), table1, 16'h0222);
                chk($sformatf("cont pass c%0d", n), pass1, 1'b1);
            end
            if (n == 35) begin
                chk("cont cleared table", table1, 16'h0000);
                chk("cont cleared ones", ones1, 5'd0);
                chk("cont cleared pass", pass1, 1'b0);
            end
            if (n == 67) start1 = 1'b0;
        end
        @(negedge clk);
        chk("cont idle busy", busy1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
